pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central hazard/stall sequencer for the 5-stage pipeline. Drives the enable of the
//  PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and a bubble (NOP insert)
//  into ID/EX. Handles three cases: multi-cycle DIV/DIVU occupancy of EX (full freeze
//  with start/done handshake and watchdog), load-use hazards, and exception/ERET
//  flush of IF/ID. Also keeps a saturating stall-cycle counter.
// PARAMETERS
//  MAX_WAIT  64  DIV_WAIT cycles allowed before the watchdog forces release (>=2)
//  CNT_W     16  width of stall_cnt
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  id_rs_addr    in   5      rs field of the instruction in ID
//  id_rt_addr    in   5      rt field of the instruction in ID
//  id_rs_used    in   1      ID instruction reads rs
//  id_rt_used    in   1      ID instruction reads rt
//  ex_rd_waddr   in   5      destination register of the instruction in EX
//  ex_rd_wena    in   1      EX instruction writes the register file
//  ex_is_load    in   1      EX instruction is LW/LH/LHU/LB/LBU
//  ex_div_req    in   1      EX instruction is DIV/DIVU
//  div_done      in   1      divider result valid (pulse or level)
//  exc_flush     in   1      exception/ERET taken in ID; redirect PC
//  pc_ena        out  1      PC register enable
//  if_id_ena     out  1      IF/ID enable
//  if_id_flush   out  1      IF/ID loads NOP
//  id_ex_ena     out  1      ID/EX enable
//  id_ex_bubble  out  1      ID/EX loads NOP (rd_wena=0, hi/lo_wena=0, no mem write)
//  ex_mem_ena    out  1      EX/MEM enable
//  mem_wb_ena    out  1      MEM/WB enable
//  div_start     out  1      one-cycle start pulse to the divider
//  div_timeout   out  1      sticky: watchdog released a DIV without div_done
//  stall_cnt     out  CNT_W  count of cycles with pc_ena=0, saturating at all-ones
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RUN, wait counter=0, div_start=0, div_timeout=0,
//   stall_cnt=0. Enables decode from state, so all five enables read 1 and the
//   flush/bubble outputs read 0 while in reset.
//  States: RUN, DIV_WAIT, DIV_DONE. State, div_start, the counter, div_timeout and
//   stall_cnt are registered. All enable, flush and bubble outputs are combinational
//   from state and inputs.
//  RUN, priority high to low:
//   1) ex_div_req=1: all five enables=0, flush/bubble=0; next state DIV_WAIT, counter:=0.
//      exc_flush is ignored this cycle. ID is frozen, so the source holds or re-raises it.
//   2) exc_flush=1: all enables=1, if_id_flush=1, id_ex_bubble=1.
//   3) load-use: ex_is_load & ex_rd_wena & ex_rd_waddr!=0 & ((id_rs_used &
//      id_rs_addr==ex_rd_waddr) | (id_rt_used & id_rt_addr==ex_rd_waddr)).
//      pc_ena=0, if_id_ena=0, id_ex_ena=1, id_ex_bubble=1, ex_mem_ena=1, mem_wb_ena=1.
//      Exactly one stall cycle per hazard.
//   4) otherwise all enables=1, flush/bubble=0.
//  DIV_WAIT: all five enables=0 (whole pipe frozen; repeated WB writes are idempotent).
//   div_start=1 only in the first DIV_WAIT cycle. div_done is ignored in that cycle.
//   From the second cycle on, div_done=1 -> DIV_DONE. Else counter+1.
//   If counter==MAX_WAIT-1 and no div_done -> div_timeout:=1, go to DIV_DONE.
//  DIV_DONE: one cycle, all enables=1, no start, no hazard check. The DIV instruction
//   advances to MEM. Next state RUN. This state prevents re-triggering on the same DIV.
//  exc_flush and load-use are not evaluated in DIV_WAIT or DIV_DONE.
//  stall_cnt: +1 on every clock with pc_ena=0 (includes the RUN cycle that enters
//   DIV_WAIT). Holds at 2^CNT_W-1.
//  Reset asserted mid-DIV: immediate return to RUN, div_start drops. The divider shares
//   rst_n.
//  Back-to-back DIVs: the second DIV reaches EX in RUN after DIV_DONE and starts anew.
// TESTING
//  1 Reset: rst_n=0 mid-run -> state RUN, stall_cnt=0, div_start=0, all enables=1.
//  2 LW $5 in EX, ADD using rs=$5 in ID -> exactly 1 cycle with pc_ena=0,
//    if_id_ena=0, id_ex_bubble=1, then normal flow. Same with rd=$0 -> no stall.
//  3 DIV in EX, div_done raised on the 10th DIV_WAIT cycle -> div_start high for 1
//    cycle, enables=0 for 11 cycles (entry cycle + 10), one DIV_DONE cycle, stall_cnt+=11.
//  4 div_done held at 1 from entry -> ignored in the first DIV_WAIT cycle, exit after
//    the second. Never asserted -> exit after MAX_WAIT=64 cycles, div_timeout=1 sticky.
//  5 exc_flush together with a load-use hazard -> if_id_flush=1, id_ex_bubble=1,
//    pc_ena=1. exc_flush together with ex_div_req -> DIV wins, flush ignored.
//  6 rst_n pulsed low at DIV_WAIT cycle 5 -> RUN, div_start=0. Two DIVs back to back ->
//    two separate div_start pulses. CNT_W=4 -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard/stall sequencer for the 5-stage pipeline.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   id_rs_addr/id_rt_addr/_used        register reads of the ID instruction
//   ex_rd_waddr/ex_rd_wena/ex_is_load  destination/write/load flags of EX
//   ex_div_req, div_done               DIV occupancy of EX and divider completion
//   exc_flush                          exception/ERET redirect from ID
//   pc_ena .. mem_wb_ena               stage register enables
//   if_id_flush, id_ex_bubble          NOP insertion into IF/ID and ID/EX
//   div_start, div_timeout             divider start pulse, sticky watchdog flag
//   stall_cnt                          saturating count of cycles with pc_ena=0
module pipe_stall_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [4:0]       ex_rd_waddr,
  input  logic             ex_rd_wena,
  input  logic             ex_is_load,
  input  logic             ex_div_req,
  input  logic             div_done,
  input  logic             exc_flush,
  output logic             pc_ena,
  output logic             if_id_ena,
  output logic             if_id_flush,
  output logic             id_ex_ena,
  output logic             id_ex_bubble,
  output logic             ex_mem_ena,
  output logic             mem_wb_ena,
  output logic             div_start,
  output logic             div_timeout,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(MAX_WAIT);
  typedef enum logic [1:0] {RUN, DIV_WAIT, DIV_DONE} state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             div_start_q, div_start_d;
  logic             div_timeout_q, div_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use, div_hit, flush_hit, lu_hit, frz;
  assign div_start   = div_start_q;
  assign div_timeout = div_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign load_use = ex_is_load & ex_rd_wena & (ex_rd_waddr != 5'd0) &
                    ((id_rs_used & (id_rs_addr == ex_rd_waddr)) |
                     (id_rt_used & (id_rt_addr == ex_rd_waddr)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wcnt_q        <= '0;
      div_start_q   <= 1'b0;
      div_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      div_start_q   <= div_start_d;
      div_timeout_q <= div_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end
  // div_start_q is high exactly in the first DIV_WAIT cycle, so it doubles as
  // the marker for the cycle in which div_done must be ignored.
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    div_start_d   = 1'b0;
    div_timeout_d = div_timeout_q;
    stall_cnt_d   = (!pc_ena && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    case (state_q)
      RUN: begin
        if (ex_div_req) begin
          state_d     = DIV_WAIT;
          wcnt_d      = '0;
          div_start_d = 1'b1;
        end
      end
      DIV_WAIT: begin
        if (!div_start_q && div_done) state_d = DIV_DONE;
        else if (wcnt_q == WW'(MAX_WAIT - 1)) begin
          state_d       = DIV_DONE;
          div_timeout_d = 1'b1;
        end else wcnt_d = wcnt_q + 1'b1;
      end
      default: state_d = RUN;
    endcase
  end
  // Priority in RUN: DIV entry, then exception flush, then load-use stall.
  always_comb begin
    div_hit      = (state_q == RUN) & ex_div_req;
    flush_hit    = (state_q == RUN) & ~ex_div_req & exc_flush;
    lu_hit       = (state_q == RUN) & ~ex_div_req & ~exc_flush & load_use;
    frz          = div_hit | (state_q == DIV_WAIT);
    pc_ena       = ~(frz | lu_hit);
    if_id_ena    = ~(frz | lu_hit);
    id_ex_ena    = ~frz;
    ex_mem_ena   = ~frz;
    mem_wb_ena   = ~frz;
    if_id_flush  = flush_hit;
    id_ex_bubble = flush_hit | lu_hit;
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scoreboard bench for pipe_stall_ctrl (CNT_W=4, MAX_WAIT=64).
module tb_pipe_stall_ctrl;
  // expected flag order: pc, if_id, flush, id_ex, bubble, ex_mem, mem_wb, start, timeout
  localparam logic [8:0] RUNV = 9'b110101100;
  localparam logic [8:0] FRZ  = 9'b000000000;
  localparam logic [8:0] FRZS = 9'b000000010;
  localparam logic [8:0] LU   = 9'b000111100;
  localparam logic [8:0] FL   = 9'b111111100;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs_addr, id_rt_addr, ex_rd_waddr;
  logic       id_rs_used, id_rt_used, ex_rd_wena, ex_is_load, ex_div_req, div_done, exc_flush;
  logic       pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_bubble, ex_mem_ena, mem_wb_ena;
  logic       div_start, div_timeout;
  logic [3:0] stall_cnt;
  logic [12:0] sb[$];
  logic [3:0] exp_cnt = 4'd0;
  logic       exp_tmo = 1'b0;
  int         errs = 0;
  int         checks = 0;

  pipe_stall_ctrl #(.MAX_WAIT(64), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rd_waddr(ex_rd_waddr), .ex_rd_wena(ex_rd_wena), .ex_is_load(ex_is_load),
    .ex_div_req(ex_div_req), .div_done(div_done), .exc_flush(exc_flush),
    .pc_ena(pc_ena), .if_id_ena(if_id_ena), .if_id_flush(if_id_flush),
    .id_ex_ena(id_ex_ena), .id_ex_bubble(id_ex_bubble), .ex_mem_ena(ex_mem_ena),
    .mem_wb_ena(mem_wb_ena), .div_start(div_start), .div_timeout(div_timeout),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; ex_rd_waddr = 5'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_rd_wena = 1'b0; ex_is_load = 1'b0;
    ex_div_req = 1'b0; div_done = 1'b0; exc_flush = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu);
    idle();
    ex_is_load = 1'b1; ex_rd_wena = 1'b1; ex_rd_waddr = rd;
    id_rs_addr = rs; id_rs_used = rsu; id_rt_addr = rt; id_rt_used = rtu;
  endtask

  task automatic check(input string tag);
    logic [12:0] e, o;
    e = sb.pop_front();
    o = {pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_bubble, ex_mem_ena,
         mem_wb_ena, div_start, div_timeout, stall_cnt};
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // one clock cycle with the current inputs; e holds the expected flags
  task automatic cyc(input string tag, input logic [8:0] e);
    sb.push_back({e | {8'b0, exp_tmo}, exp_cnt});
    @(negedge clk);
    check(tag);
    if (!e[8] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle();
    exp_cnt = 4'd0;
    exp_tmo = 1'b0;
    sb.push_back({RUNV, 4'd0});
    #2;
    check(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    do_reset("reset_initial");
    cyc("run_idle", RUNV);
    // load-use hazards
    load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); cyc("lu_rs", LU);
    idle();                             cyc("lu_after", RUNV);
    load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); cyc("lu_r0", RUNV);
    load(5'd7, 5'd1, 1'b1, 5'd7, 1'b1); cyc("lu_rt", LU);
    idle();                             cyc("lu_rt_after", RUNV);
    load(5'd7, 5'd1, 1'b1, 5'd7, 1'b0); cyc("lu_rt_unused", RUNV);
    load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); ex_is_load = 1'b0; cyc("no_load", RUNV);
    // DIV with done on the 10th wait cycle
    idle(); ex_div_req = 1'b1;  cyc("div_entry", FRZ);
    cyc("div_w1_start", FRZS);
    for (int i = 2; i <= 9; i++) cyc("div_wait", FRZ);
    div_done = 1'b1;            cyc("div_w10_done", FRZ);
    div_done = 1'b0;            cyc("div_done_state", RUNV);
    idle();                     cyc("div_after", RUNV);
    // div_done held from entry: ignored in the first wait cycle
    ex_div_req = 1'b1; div_done = 1'b1; cyc("dh_entry", FRZ);
    cyc("dh_w1_ignored", FRZS);
    cyc("dh_w2", FRZ);
    cyc("dh_done_state", RUNV);
    idle();                     cyc("dh_after", RUNV);
    // exception with load-use, exception with DIV
    load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); exc_flush = 1'b1; cyc("exc_lu", FL);
    idle(); exc_flush = 1'b1;   cyc("exc_only", FL);
    ex_div_req = 1'b1;          cyc("exc_div_entry", FRZ);
    cyc("exc_div_w1", FRZS);
    div_done = 1'b1;            cyc("exc_div_w2", FRZ);
    div_done = 1'b0;            cyc("exc_div_done_state", RUNV);
    idle();                     cyc("exc_div_after", RUNV);
    // watchdog: no div_done at all, stall_cnt saturated at 15
    ex_div_req = 1'b1;          cyc("to_entry", FRZ);
    cyc("to_w1", FRZS);
    for (int i = 2; i <= 64; i++) cyc("to_wait", FRZ);
    exp_tmo = 1'b1;
    cyc("to_done_state", RUNV);
    idle();                     cyc("to_sticky", RUNV);
    load(5'd3, 5'd0, 1'b0, 5'd3, 1'b1); cyc("to_sticky_lu", LU);
    // reset in DIV_WAIT cycle 5
    idle(); ex_div_req = 1'b1;  cyc("rd_entry", FRZ);
    cyc("rd_w1", FRZS);
    for (int i = 2; i <= 4; i++) cyc("rd_wait", FRZ);
    do_reset("reset_mid_div");
    cyc("rd_run", RUNV);
    // back-to-back DIVs produce two start pulses
    ex_div_req = 1'b1;          cyc("bb1_entry", FRZ);
    cyc("bb1_w1", FRZS);
    div_done = 1'b1;            cyc("bb1_w2", FRZ);
    div_done = 1'b0;            cyc("bb1_done_state", RUNV);
    cyc("bb2_entry", FRZ);
    cyc("bb2_w1", FRZS);
    div_done = 1'b1;            cyc("bb2_w2", FRZ);
    div_done = 1'b0;            cyc("bb2_done_state", RUNV);
    idle();                     cyc("bb_after", RUNV);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
